// File: rtl/cp0_unit.sv
// cp0_unit -- Coprocessor-0 for the P7 pipelined MIPS core (M stage).
// Holds SR, Cause, EPC and PRId, decides interrupt/exception entry and
// drives the fetch redirect request, the saved return PC and mfc0 data.
// Optional build macro: CP0_BD_EN -- when defined, entry records the branch
// delay flag in Cause.BD and backs EPC up to the branch; when undefined,
// Cause.BD reads 0, EPC is always the victim PC and BDIn is ignored.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2021_0707,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          A1,
    input  logic [4:0]          A2,
    input  logic [31:0]         DIn,
    input  logic                WE,
    input  logic [31:0]         VPC,
    input  logic                BDIn,
    input  logic [4:0]          ExcCodeIn,
    input  logic [HW_INT_W-1:0] HWInt,
    input  logic                EXLClr,
    output logic                IntReq,
    output logic [31:0]         EPCOut,
    output logic [31:0]         DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Architectural state, kept as the individual fields that exist.
    logic [HW_INT_W-1:0] sr_im;
    logic                sr_exl;
    logic                sr_ie;
    logic                cause_bd;
    logic [HW_INT_W-1:0] cause_ip;
    logic [4:0]          cause_exc;
    logic [31:2]         epc;

    logic        int_hit;
    logic        exc_hit;
    logic [31:0] epc_entry;

    // Request decision: interrupts need IE and an enabled line; everything
    // is masked while EXL is set, and reset suppresses the request.
    always_comb begin
        int_hit = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_hit = (ExcCodeIn != 5'd0) & ~sr_exl;
        IntReq  = (int_hit | exc_hit) & ~reset;
    end

    // Return address captured on entry.
`ifdef CP0_BD_EN
    always_comb begin
        epc_entry = BDIn ? (VPC - 32'd4) : VPC;
    end
`else
    always_comb begin
        epc_entry = VPC;
    end
`endif

    // Low PC bits never reach EPC; BDIn is only consumed with CP0_BD_EN.
    logic unused_ok;
    assign unused_ok = ^{epc_entry[1:0], DIn[1:0] & 2'b00, BDIn};

    // State update: entry beats mtc0; eret clears EXL after any mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= 5'd0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (IntReq) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_hit ? 5'd0 : ExcCodeIn;
                epc       <= epc_entry[31:2];
`ifdef CP0_BD_EN
                cause_bd  <= BDIn;
`else
                cause_bd  <= 1'b0;
`endif
            end else begin
                if (WE) begin
                    case (A2)
                        REG_SR: begin
                            sr_im  <= DIn[15:10];
                            sr_exl <= DIn[1];
                            sr_ie  <= DIn[0];
                        end
                        REG_EPC: epc <= DIn[31:2];
                        default: ;
                    endcase
                end
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux and EPC export, straight from current state.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            REG_CAUSE: DOut = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
            REG_EPC:   DOut = {epc, 2'b00};
            REG_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
        EPCOut = {epc, 2'b00};
    end

endmodule
